// File: rtl/chacha_aead_pkg.sv
// Shared types and helpers for the ChaCha20-Poly1305 message framer.
// The length-limit feature is selected by CHACHA_LEN_LIMIT_EN in the framer top.
package chacha_aead_pkg;

  localparam int DATA_W = 128;
  localparam int KEEP_W = DATA_W / 8;
  localparam int LEN_W  = 64;
  localparam int CNT_W  = $clog2(KEEP_W) + 1;
  localparam logic [63:0] MAX_PLD_BYTES = 64'd274877906880;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AAD   = 3'd1,
    ST_PLD   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LEN   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  typedef enum logic {
    DEST_AAD = 1'b0,
    DEST_PLD = 1'b1
  } dest_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    dest_e             dest;
  } beat_t;

  function automatic logic [CNT_W-1:0] keep_popcount(input logic [KEEP_W-1:0] keep);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + CNT_W'(keep[i]);
    return n;
  endfunction

  // Legal keeps are 2^n-1: once a zero bit is seen no higher bit may be set.
  function automatic logic keep_contiguous(input logic [KEEP_W-1:0] keep);
    logic seen_zero, ok;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (!keep[i])       seen_zero = 1'b1;
      else if (seen_zero) ok        = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/aead_out_reg.sv
// One-entry valid/ready output register; bytes whose keep bit is clear are
// zeroed on load so the core sees Poly1305 zero padding.
module aead_out_reg
  import chacha_aead_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load,
  input  beat_t in_beat,
  input  logic  out_ready,
  output logic  out_v,
  output beat_t out_beat
);

  logic [DATA_W-1:0] masked;

  for (genvar b = 0; b < KEEP_W; b++) begin : g_lane
    assign masked[8*b +: 8] = in_beat.data[8*b +: 8] & {8{in_beat.keep[b]}};
  end

  // load is only raised when the entry is empty or draining this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v    <= 1'b0;
      out_beat <= '0;
    end else if (clr) begin
      out_v <= 1'b0;
    end else if (load) begin
      out_v    <= 1'b1;
      out_beat <= '{data: masked, keep: in_beat.keep, dest: in_beat.dest};
    end else if (out_ready) begin
      out_v <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha20_poly1305_framer.sv
// AEAD message framer: routes AAD/payload beats to the core, counts bytes and
// emits the length block. Define CHACHA_LEN_LIMIT_EN to enforce MAX_PLD_BYTES.
module chacha20_poly1305_framer #(
  parameter int          DATA_W        = chacha_aead_pkg::DATA_W,
  parameter int          KEEP_W        = chacha_aead_pkg::KEEP_W,
  parameter int          LEN_W         = chacha_aead_pkg::LEN_W,
  parameter logic [63:0] MAX_PLD_BYTES = chacha_aead_pkg::MAX_PLD_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [KEEP_W-1:0]    in_keep,
  input  logic                 in_is_aad,
  input  logic                 in_last,
  output logic                 aad_valid,
  output logic [DATA_W-1:0]    aad_data,
  output logic [KEEP_W-1:0]    aad_keep,
  input  logic                 aad_ready,
  output logic                 pld_valid,
  output logic [DATA_W-1:0]    pld_data,
  output logic [KEEP_W-1:0]    pld_keep,
  input  logic                 pld_ready,
  output logic                 len_valid,
  output logic [2*LEN_W-1:0]   len_block,
  input  logic                 len_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  import chacha_aead_pkg::*;

`ifdef CHACHA_LEN_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_e           state;
  logic [LEN_W-1:0] aad_bytes, pld_bytes;
  logic             aad_short;
  logic             obuf_v, dest_ready, acc, bad, over, beat_ok, beat_err, load;
  beat_t            obuf, in_beat;
  logic [CNT_W-1:0] pc;
  logic [LEN_W:0]   pld_sum;

  assign dest_ready = (obuf.dest == DEST_PLD) ? pld_ready : aad_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_AAD, ST_PLD: in_ready = !obuf_v || dest_ready;
      ST_ERR:         in_ready = 1'b1;
      default:        in_ready = 1'b0;
    endcase
  end

  // start wins over a same-cycle accept; ERR-state beats never reach acc
  assign acc = in_valid && in_ready && !start && (state == ST_AAD || state == ST_PLD);
  assign pc  = keep_popcount(in_keep);

  assign pld_sum = {1'b0, pld_bytes} + (LEN_W+1)'(pc);
  assign over    = LIMIT_EN && !in_is_aad && (pld_sum > (LEN_W+1)'(MAX_PLD_BYTES));

  // A short AAD beat without in_last is allowed once: the next beat must be payload.
  assign bad = !keep_contiguous(in_keep)
             || (in_keep == '0 && !in_last)
             || (in_is_aad && (state == ST_PLD || aad_short))
             || (!in_is_aad && !in_last && in_keep != '1)
             || over;

  assign beat_ok  = acc && !bad;
  assign beat_err = acc && bad;
  assign load     = beat_ok && (in_keep != '0);

  assign in_beat = '{data: in_data, keep: in_keep, dest: in_is_aad ? DEST_AAD : DEST_PLD};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      aad_bytes <= '0;
      pld_bytes <= '0;
      aad_short <= 1'b0;
      err       <= 1'b0;
      len_valid <= 1'b0;
      len_block <= '0;
    end else if (start) begin
      state     <= ST_AAD;
      aad_bytes <= '0;
      pld_bytes <= '0;
      aad_short <= 1'b0;
      err       <= 1'b0;
      len_valid <= 1'b0;
    end else begin
      case (state)
        ST_AAD, ST_PLD: begin
          if (beat_err) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else if (beat_ok) begin
            if (in_is_aad) aad_bytes <= aad_bytes + LEN_W'(pc);
            else           pld_bytes <= pld_bytes + LEN_W'(pc);
            aad_short <= in_is_aad && (in_keep != '1);
            if (in_last)        state <= ST_DRAIN;
            else if (in_is_aad) state <= ST_AAD;
            else                state <= ST_PLD;
          end
        end
        ST_DRAIN: begin
          if (!obuf_v) begin
            state     <= ST_LEN;
            len_valid <= 1'b1;
            len_block <= {pld_bytes, aad_bytes};
          end
        end
        ST_LEN: begin
          if (len_ready) begin
            state     <= ST_DONE;
            len_valid <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= state;
      endcase
    end
  end

  aead_out_reg u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .load      (load),
    .in_beat   (in_beat),
    .out_ready (dest_ready),
    .out_v     (obuf_v),
    .out_beat  (obuf)
  );

  assign aad_valid = obuf_v && (obuf.dest == DEST_AAD);
  assign pld_valid = obuf_v && (obuf.dest == DEST_PLD);
  assign aad_data  = obuf.data;
  assign aad_keep  = obuf.keep;
  assign pld_data  = obuf.data;
  assign pld_keep  = obuf.keep;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_chacha20_poly1305_framer.sv
// Self-checking bench for chacha20_poly1305_framer: message-level model with
// expected-beat and length queues, random data/structure/backpressure.
module tb_chacha20_poly1305_framer;

`ifdef CHACHA_LEN_LIMIT_EN
  localparam logic [63:0] TB_MAX = 64'd32;
  localparam bit          LIM    = 1'b1;
`else
  localparam logic [63:0] TB_MAX = 64'd274877906880;
  localparam bit          LIM    = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic in_valid = 1'b0, in_is_aad = 1'b0, in_last = 1'b0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_keep = '0;
  logic aad_ready = 1'b1, pld_ready = 1'b1, len_ready = 1'b1;
  logic in_ready, aad_valid, pld_valid, len_valid, busy, done, err;
  logic [127:0] aad_data, pld_data, len_block;
  logic [15:0]  aad_keep, pld_keep;

  chacha20_poly1305_framer #(.MAX_PLD_BYTES(TB_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_is_aad(in_is_aad), .in_last(in_last),
    .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
    .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         dest;
    logic [127:0] data;
    logic [15:0]  keep;
  } obeat_t;

  obeat_t       exp_q[$];
  logic [127:0] exp_len_q[$];
  logic [127:0] b_data[$];
  logic [15:0]  b_keep[$];
  logic         b_aad[$];
  logic [127:0] last_len = '0, last_aad = '0, last_pld = '0;
  int           done_cnt = 0;
  logic         rdy_rand = 1'b0, pld_hold = 1'b0;
  logic         stall_v = 1'b0;
  logic [159:0] stall_val = '0;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) begin
      aad_ready = ($urandom % 4) != 0;
      pld_ready = ($urandom % 4) != 0;
      len_ready = ($urandom % 3) != 0;
    end else begin
      aad_ready = 1'b1;
      pld_ready = !pld_hold;
      len_ready = 1'b1;
    end
  end

  task automatic pop_beat(input logic dest, input logic [127:0] data, input logic [15:0] keep);
    obeat_t e;
    if (exp_q.size() == 0) begin
      check("beat_unexpected", {dest, keep, data}, '1);
    end else begin
      e = exp_q.pop_front();
      check("beat", {dest, keep, data}, {e.dest, e.keep, e.data});
    end
  endtask

  // compare process: every output transfer is checked against the model queues
  always @(negedge clk) begin
    logic [159:0] cur;
    if (rst_n) begin
      cur = pld_valid ? {15'd0, 1'b1, pld_keep, pld_data} : {15'd0, 1'b0, aad_keep, aad_data};
      if (stall_v && (aad_valid || pld_valid)) check("hold_stable", cur, stall_val);
      stall_v   = (aad_valid && !aad_ready) || (pld_valid && !pld_ready);
      stall_val = cur;
      if (aad_valid && pld_valid) check("one_dest", {aad_valid, pld_valid}, 2'b10);
      if (aad_valid && aad_ready) begin pop_beat(1'b0, aad_data, aad_keep); last_aad = aad_data; end
      if (pld_valid && pld_ready) begin pop_beat(1'b1, pld_data, pld_keep); last_pld = pld_data; end
      if (len_valid) begin
        if (exp_len_q.size() == 0) check("len_unexpected", len_valid, 1'b0);
        else if (len_ready) begin
          check("len_block", len_block, exp_len_q.pop_front());
          last_len = len_block;
        end
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [15:0] km(input int n);
    logic [16:0] one;
    one = 17'd1;
    return (n >= 16) ? 16'hFFFF : 16'((one << n) - 17'd1);
  endfunction

  task automatic add(input logic aad, input logic [15:0] keep);
    b_data.push_back({$urandom, $urandom, $urandom, $urandom});
    b_keep.push_back(keep);
    b_aad.push_back(aad);
  endtask

  task automatic start_msg();
    @(posedge clk); #1;
    start = 1'b1;
    exp_q.delete();
    exp_len_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_err_clr", err, 1'b0);
    check("start_busy", busy, 1'b1);
    @(posedge clk); #1;
  endtask

  // Model walks the message by the protocol rules, queues expectations, then drives it.
  task automatic send_msg(input bit close, input bit chk_lat);
    int n, d0;
    bit in_pld, short_aad, merr, got;
    logic [63:0] aadb, pldb;
    logic [15:0] k;
    logic [127:0] m;
    int pc;
    bit last, bad;
    obeat_t e;
    n = b_keep.size();
    in_pld = 0; short_aad = 0; merr = 0; aadb = 0; pldb = 0;
    for (int i = 0; i < n && !merr; i++) begin
      k = b_keep[i];
      last = (i == n - 1) && close;
      pc = 0;
      m = '0;
      for (int j = 0; j < 16; j++) if (k[j]) begin pc++; m[8*j +: 8] = 8'hFF; end
      bad = ((k & (k + 16'd1)) != 16'd0) || (k == 16'd0 && !last)
         || (b_aad[i] && (in_pld || short_aad))
         || (!b_aad[i] && !last && k != 16'hFFFF)
         || (LIM && !b_aad[i] && (pldb + 64'(pc) > TB_MAX));
      if (bad) merr = 1;
      else begin
        if (k != 16'd0) begin
          e.dest = !b_aad[i]; e.data = b_data[i] & m; e.keep = k;
          exp_q.push_back(e);
        end
        if (b_aad[i]) aadb += 64'(pc);
        else begin pldb += 64'(pc); in_pld = 1; end
        short_aad = b_aad[i] && k != 16'hFFFF;
      end
    end
    if (!merr && close) exp_len_q.push_back({pldb, aadb});
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = b_data[i]; in_keep = b_keep[i];
      in_is_aad = b_aad[i]; in_last = (i == n - 1) && close;
      got = 0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (in_ready) got = 1;
      end
      if (!got) begin
        check("in_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        b_data.delete(); b_keep.delete(); b_aad.delete();
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    b_data.delete(); b_keep.delete(); b_aad.delete();
    if (!close) return;
    if (chk_lat) begin
      @(negedge clk); check("lat_len_low", len_valid, 1'b0);
      @(negedge clk); check("lat_len_high", len_valid, 1'b1);
    end
    if (!merr) begin
      for (int t = 0; t < 300 && done_cnt == d0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("beats_drained", 32'(exp_q.size()), 32'd0);
      check("busy_idle", busy, 1'b0);
    end else begin
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
      @(negedge clk);
      check("beats_drained", 32'(exp_q.size()), 32'd0);
      check("err_set", err, 1'b1);
      check("err_no_done", 32'(done_cnt - d0), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int na, np;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valids", {aad_valid, pld_valid, len_valid}, 3'b000);
    check("rst_len_block", len_block, 128'd0);
    check("rst_data", {aad_data, aad_keep}, 144'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic message
    add(1, 16'hFFFF); add(1, 16'hFFFF);
    add(0, 16'hFFFF); add(0, 16'hFFFF); add(0, 16'hFFFF);
    start_msg(); send_msg(1, 0);
    check("t1_len", last_len, {64'd48, 64'd32});

    // partial AAD then partial payload: padding zeroes
    add(1, 16'h0FFF); add(0, 16'h001F);
    start_msg(); send_msg(1, 0);
    check("t2_len", last_len, {64'd5, 64'd12});
    check("t2_aad_pad", last_aad[127:96], 32'd0);
    check("t2_pld_pad", last_pld[127:40], 88'd0);

    // payload backpressure for several cycles
    pld_hold = 1'b1;
    add(1, 16'hFFFF);
    for (int i = 0; i < 4; i++) add(0, 16'hFFFF);
    start_msg();
    fork
      send_msg(1, 0);
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_pld_valid", pld_valid, 1'b1);
        pld_hold = 1'b0;
      end
    join
    check("t3_len", last_len, {64'd64, 64'd16});

    // protocol errors
    add(1, 16'hFFFF); add(1, 16'h00F0); add(1, 16'hFFFF);
    start_msg(); send_msg(1, 0);
    add(1, 16'hFFFF); add(0, 16'hFFFF); add(1, 16'hFFFF);
    start_msg(); send_msg(1, 0);

    // empty message
    add(0, 16'h0000);
    start_msg(); send_msg(1, 1);
    check("t5_len", last_len, 128'd0);

    // abort with the output register full
    pld_hold = 1'b1;
    add(1, 16'hFFFF); add(0, 16'hFFFF);
    start_msg(); send_msg(0, 0);
    repeat (2) @(negedge clk);
    check("t6_obuf_full", pld_valid, 1'b1);
    start_msg();
    check("t6_pld_drop", pld_valid, 1'b0);
    pld_hold = 1'b0;
    add(1, 16'h0003); add(0, 16'hFFFF); add(0, 16'h00FF);
    send_msg(1, 0);
    check("t6_len", last_len, {64'd24, 64'd2});

`ifdef CHACHA_LEN_LIMIT_EN
    add(0, 16'hFFFF); add(0, 16'hFFFF); add(0, 16'hFFFF);
    start_msg(); send_msg(1, 0);
`endif

    // random structure, data, error injection and backpressure
    rdy_rand = 1'b1;
    repeat (40) begin
      na = $urandom % 4;
      np = $urandom % 4;
      for (int i = 0; i < na; i++) add(1, 16'hFFFF);
      if ($urandom % 2) add(1, km(1 + $urandom % 15));
      for (int i = 0; i < np; i++) add(0, 16'hFFFF);
      if (np != 0 && ($urandom % 2)) add(0, km($urandom % 16));
      if (b_keep.size() == 0) add($urandom % 2, 16'h0000);
      if ($urandom % 5 == 0) begin
        int idx;
        idx = $urandom % b_keep.size();
        case ($urandom % 3)
          0: b_keep[idx] = 16'h0F0F;
          1: b_aad[idx]  = 1'b1;
          default: b_keep[idx] = 16'h0000;
        endcase
      end
      start_msg(); send_msg(1, 0);
    end
    rdy_rand = 1'b0;

    // reset in the middle of a message
    add(1, 16'hFFFF); add(1, 16'hFFFF);
    start_msg(); send_msg(0, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", {busy, err, done, aad_valid, pld_valid, len_valid}, 6'd0);
    check("mid_rst_len", len_block, 128'd0);
    exp_q.delete(); exp_len_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
